// File: rtl/vga_pkg.sv
// Shared VGA/game definitions: screen selector states and game-flow defaults.
package vga_pkg;

    // Screen currently driving the VGA image mux
    typedef enum logic [1:0] {
        START    = 2'd0,
        GAME     = 2'd1,
        PLAYER_1 = 2'd2,
        PLAYER_2 = 2'd3
    } state;

    // Points at which a player wins the round
    localparam int WIN_POINTS_DEF  = 10;

    // Frames a win screen stays up before returning to the menu
    localparam int HOLD_FRAMES_DEF = 300;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a raw push button followed by a rising-edge
// detector; emits a single-cycle pulse per press. Reusable for any button.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Bring the button into the clock domain and remember the last synced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow controller: chooses which screen the VGA selector shows and
// only commits a change on a vsync rising edge so images never tear.
module game_state_ctrl
    import vga_pkg::*;
#(
    parameter int WIN_POINTS  = WIN_POINTS_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       btn_start,
    input  logic [3:0] points_p1,
    input  logic [3:0] points_p2,
    output state       screen,
    output logic       game_rst,
    output logic       screen_chg
);

    localparam logic [3:0]  WinThr   = WIN_POINTS[3:0];
    localparam logic [15:0] HoldLast = 16'(HOLD_FRAMES - 1);

    state        screen_q, screen_d;
    logic        vsync_q;
    logic        start_req_q, start_req_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        game_rst_q, game_rst_d;
    logic        screen_chg_q, screen_chg_d;
    logic        tick;
    logic        press;

    btn_sync_edge u_start_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_start),
        .pulse_o (press)
    );

    assign tick = vsync & ~vsync_q;

    // Register the screen, the pending start request, the win-hold counter and the pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            screen_q     <= START;
            vsync_q      <= 1'b0;
            start_req_q  <= 1'b0;
            hold_cnt_q   <= 16'd0;
            game_rst_q   <= 1'b0;
            screen_chg_q <= 1'b0;
        end else begin
            screen_q     <= screen_d;
            vsync_q      <= vsync;
            start_req_q  <= start_req_d;
            hold_cnt_q   <= hold_cnt_d;
            game_rst_q   <= game_rst_d;
            screen_chg_q <= screen_chg_d;
        end
    end

    // Decide the next screen; every change except recovery waits for a frame tick
    always_comb begin
        screen_d    = screen_q;
        start_req_d = start_req_q;
        hold_cnt_d  = hold_cnt_q;
        game_rst_d  = 1'b0;

        case (screen_q)
            START: begin
                if (tick && start_req_q) begin
                    screen_d    = GAME;
                    start_req_d = 1'b0;
                    game_rst_d  = 1'b1;
                end else if (press) begin
                    start_req_d = 1'b1;
                end
            end
            GAME: begin
                start_req_d = 1'b0;
                if (tick) begin
                    if (points_p1 >= WinThr) begin
                        screen_d   = PLAYER_1;
                        hold_cnt_d = 16'd0;
                    end else if (points_p2 >= WinThr) begin
                        screen_d   = PLAYER_2;
                        hold_cnt_d = 16'd0;
                    end
                end
            end
            PLAYER_1, PLAYER_2: begin
                start_req_d = 1'b0;
                if (tick) begin
                    if (hold_cnt_q == HoldLast) begin
                        screen_d   = START;
                        hold_cnt_d = 16'd0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                screen_d    = START;
                start_req_d = 1'b0;
                hold_cnt_d  = 16'd0;
            end
        endcase

        screen_chg_d = (screen_d != screen_q);
    end

    assign screen     = screen_q;
    assign game_rst   = game_rst_q;
    assign screen_chg = screen_chg_q;

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Produces the `screen` state that selects which VGA image stream (main menu, game, player-1-won, player-2-won) drives the display.
- Tracks the game flow from the start button and both players' point counts.
- Commits every screen change only at a frame boundary (vsync rising edge), so the selector never switches mid-frame.
- Sits beside the screen selector in the top level. It reads the selector's `points` output (local player) and the remote player's points, and issues a scoring reset when a new game begins.

Parameters:
- WIN_POINTS, 10, points (unsigned, 1..15) at which a player wins.
- HOLD_FRAMES, 300, frames a win screen is held before returning to START (1..65535).

Ports:
- clk  in  1  system/pixel clock, same domain as the VGA timing.
- rst_n  in  1  asynchronous reset, active-low.
- vsync  in  1  vertical sync from the VGA timing interface; its rising edge is the frame tick.
- btn_start  in  1  raw start button, asynchronous to clk.
- points_p1  in  4  local player points (unsigned).
- points_p2  in  4  remote player points (unsigned).
- screen  out  state  current screen (START, GAME, PLAYER_1, PLAYER_2).
- game_rst  out  1  one-cycle pulse on entry to GAME; clears the scoring logic.
- screen_chg  out  1  one-cycle pulse in the cycle `screen` changes.

Behaviour:
- Reset:
  - Applied asynchronously on rst_n=0.
  - Values: screen=START, game_rst=0, screen_chg=0, start_req=0, hold_cnt=0, sync flops=0, vsync_d=0.
- Frame tick:
  - vsync_d is the registered vsync.
  - tick = vsync & ~vsync_d, so there is exactly one tick per frame.
  - The first tick after reset requires a 0→1 transition of vsync.
- Start button:
  - Passes through a 2-flop synchroniser, then a rising-edge detector, giving a press pulse.
  - A press seen while screen=START sets the sticky start_req.
  - start_req clears when consumed or whenever screen≠START.
  - Presses in GAME, PLAYER_1 and PLAYER_2 are ignored.
  - Latency: a btn_start edge becomes start_req 3 clocks later.
- State transitions (all evaluated only in a cycle with tick=1; the new screen is visible on the next clock edge):
  - START → GAME if start_req=1. In that same edge: game_rst=1 for one cycle, start_req cleared.
  - GAME → PLAYER_1 if points_p1 ≥ WIN_POINTS.
  - GAME → PLAYER_2 if points_p2 ≥ WIN_POINTS and points_p1 < WIN_POINTS. When both players reach WIN_POINTS on the same tick, PLAYER_1 wins.
  - PLAYER_1/PLAYER_2:
    - hold_cnt (16 bit) is cleared on entry and incremented per tick.
    - When the tick sees hold_cnt = HOLD_FRAMES-1, the block goes to START and clears hold_cnt.
    - The win screen therefore lasts exactly HOLD_FRAMES ticks.
  - Any undefined encoding of screen → START on the next clock (no tick required).
- Points handling:
  - Points are sampled only at the tick. Values between ticks have no effect.
  - Comparison is 4-bit unsigned; no saturation or wrap handling is required.
- screen_chg pulses in the same cycle the screen register takes a new value; game_rst pulses coincident with screen_chg on the START→GAME change.
- Reset mid-game: rst_n low at any point returns to START immediately and drops any pending start_req. game_rst is not asserted by reset.
- A press arriving in the same cycle as the tick in START is registered as start_req and consumed at the next tick, one frame later.

Decomposition:
- The `state` enum (START, GAME, PLAYER_1, PLAYER_2) stays in vga_pkg. Add to vga_pkg: WIN_POINTS_DEF, HOLD_FRAMES_DEF.
- One sub-module: btn_sync_edge, containing the 2-flop synchroniser plus rising-edge pulse and an asynchronous active-low reset. It is reusable for the move buttons.

Test Plan:
- Reset → screen=START, game_rst=0, screen_chg=0. Then vsync toggling with no press → screen stays START for 5 frames.
- btn_start high 10 clocks mid-frame → screen stays START until the next vsync rise, then GAME on the following edge; game_rst=1 and screen_chg=1 for exactly one cycle.
- In GAME, points_p1=9 and points_p2=9 for 3 frames → GAME. points_p1=10 between ticks → no change until the next tick, then PLAYER_1.
- In GAME, points_p1=12 and points_p2=15 both before one tick → PLAYER_1 (tie priority). Separately, points_p1=3 and points_p2=10 → PLAYER_2.
- HOLD_FRAMES=4, win screen entered → START after exactly 4 ticks; btn_start pressed during the win screen → no GAME entry afterwards without a new press.
- In GAME, rst_n pulsed low for 2 clocks asynchronously mid-line → screen=START immediately, start_req=0, no game_rst pulse.
